// File: rtl/data_mem_if.sv
// Data-side bus between the core's MEM stage and data_mem.
// Signals:
//   memCe        access enable
//   memWrite     1 = store, 0 = load
//   memAddr      byte address
//   memwriteData store data
//   readData     load data, valid in the request cycle
// The master modport is the core side; the slave modport is the memory side.
interface data_mem_if;
    logic        memCe;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memwriteData;
    logic [31:0] readData;

    modport master (
        output memCe,
        output memWrite,
        output memAddr,
        output memwriteData,
        input  readData
    );

    modport slave (
        input  memCe,
        input  memWrite,
        input  memAddr,
        input  memwriteData,
        output readData
    );
endinterface

// File: rtl/data_mem.sv
// data_mem: data-side responder for the core's MEM stage.
//   Single-port word RAM (2**AW words) plus a 4-register MMIO window selected
//   by memAddr[31:16] == MMIO_HI. Loads are served combinationally in the
//   request cycle; stores commit at the next rising clk edge.
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-low reset
//   bus      data_mem_if slave: memCe, memWrite, memAddr, memwriteData, readData
//   gpioOut  GPIO register contents
//   errFlag  sticky misaligned-access flag
// MMIO map (memAddr[3:2], aliases every 16 bytes):
//   0 GPIO (R/W), 1 CYCLE (R/W, write loads), 2 ERRSTAT (write clears), 3 ERRADDR (RO)
module data_mem #(
    parameter int          AW      = 10,
    parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    data_mem_if.slave   bus,
    output logic [31:0] gpioOut,
    output logic        errFlag
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] REG_GPIO    = 2'd0;
    localparam logic [1:0] REG_CYCLE   = 2'd1;
    localparam logic [1:0] REG_ERRSTAT = 2'd2;
    localparam logic [1:0] REG_ERRADDR = 2'd3;

    logic [31:0] ram [0:DEPTH-1];

    logic [31:0] gpio_r;
    logic [31:0] cycle_r;
    logic [31:0] errAddr_r;
    logic        errFlag_r;

    logic          isMmio_s;
    logic          isMis_s;
    logic [AW-1:0] ramIdx_s;
    logic [1:0]    regSel_s;
    logic          ramWr_s;
    logic          mmioWr_s;
    logic          misAccess_s;
    logic [31:0]   readData_s;
    logic          unusedAddr_s;

    // Address decode and write qualification.
    always_comb begin
        isMmio_s     = (bus.memAddr[31:16] == MMIO_HI);
        isMis_s      = (bus.memAddr[1:0] != 2'b00);
        ramIdx_s     = bus.memAddr[AW+1:2];
        regSel_s     = bus.memAddr[3:2];
        ramWr_s      = bus.memCe & bus.memWrite & ~isMis_s & ~isMmio_s;
        mmioWr_s     = bus.memCe & bus.memWrite & ~isMis_s & isMmio_s;
        misAccess_s  = bus.memCe & isMis_s;
        // Address bits between the RAM index and the MMIO select are aliased away.
        unusedAddr_s = ^bus.memAddr;
    end

    // Zero-latency read mux; returns pre-edge state of RAM and registers.
    always_comb begin
        readData_s = 32'h0000_0000;
        if (!rst || !bus.memCe || isMis_s) begin
            readData_s = 32'h0000_0000;
        end else if (isMmio_s) begin
            case (regSel_s)
                REG_GPIO:    readData_s = gpio_r;
                REG_CYCLE:   readData_s = cycle_r;
                REG_ERRSTAT: readData_s = {31'b0, errFlag_r};
                REG_ERRADDR: readData_s = errAddr_r;
                default:     readData_s = 32'h0000_0000;
            endcase
        end else begin
            readData_s = ram[ramIdx_s];
        end
    end

    assign bus.readData = readData_s;
    assign gpioOut      = gpio_r;
    assign errFlag      = errFlag_r;

    // RAM store port; contents survive reset but stores are dropped while in reset.
    always_ff @(posedge clk) begin
        if (rst && ramWr_s) begin
            ram[ramIdx_s] <= bus.memwriteData;
        end
    end

    // MMIO registers, free-running cycle counter and misaligned-access capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gpio_r    <= 32'h0000_0000;
            cycle_r   <= 32'h0000_0000;
            errFlag_r <= 1'b0;
            errAddr_r <= 32'h0000_0000;
        end else begin
            if (mmioWr_s && (regSel_s == REG_GPIO)) begin
                gpio_r <= bus.memwriteData;
            end else begin
                gpio_r <= gpio_r;
            end

            // A store loads the exact value; counting resumes on the next edge.
            if (mmioWr_s && (regSel_s == REG_CYCLE)) begin
                cycle_r <= bus.memwriteData;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end

            // A misaligned access can never be an ERRSTAT write, so setting wins.
            if (misAccess_s) begin
                errFlag_r <= 1'b1;
                if (!errFlag_r) begin
                    errAddr_r <= bus.memAddr;
                end else begin
                    errAddr_r <= errAddr_r;
                end
            end else if (mmioWr_s && (regSel_s == REG_ERRSTAT)) begin
                errFlag_r <= 1'b0;
                errAddr_r <= errAddr_r;
            end else begin
                errFlag_r <= errFlag_r;
                errAddr_r <= errAddr_r;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem. Expected load data is pushed to a
// scoreboard queue when a load is driven and popped when readData is sampled
// at the falling edge of the same cycle.
module tb_data_mem;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpioOut;
    logic        errFlag;

    data_mem_if bus();

    data_mem #(.AW(AW), .MMIO_HI(16'hFFFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .gpioOut (gpioOut),
        .errFlag (errFlag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];
    logic [31:0] got;
    logic [31:0] exp;

    task automatic drive(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.memCe        = ce;
        bus.memWrite     = we;
        bus.memAddr      = a;
        bus.memwriteData = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        checks++; if (gpioOut !== 32'h0) begin errors++; $display("FAIL reset_gpio: got %h expected %h", gpioOut, 32'h0); end
        checks++; if (errFlag !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", errFlag, 1'b0); end
        rst = 1'b1;
        // CYCLE reads 0 in the first cycle after release, then 1.
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        expQ.push_back(32'h0);
        expQ.push_back(32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = bus.readData; exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL reset_cycle%0d: got %h expected %h", i, got, exp); end
            nextCycle();
        end
    endtask

    task automatic test_store_load();
        drive(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        nextCycle();
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        expQ.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL load_0x10: got %h expected %h", got, exp); end
        nextCycle();
        drive(1'b1, 1'b0, 32'h10 + (32'd4 << AW), 32'h0);
        expQ.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL load_alias: got %h expected %h", got, exp); end
        nextCycle();
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [4];
        addrs = '{32'hFFFF_000C, 32'h10, 32'h22, 32'hFFFF_000C};
        drive(1'b1, 1'b1, 32'h13, 32'h1111_1111);
        nextCycle();
        checks++; if (errFlag !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected %b", errFlag, 1'b1); end
        expQ.push_back(32'h13);
        expQ.push_back(32'hDEAD_BEEF);
        expQ.push_back(32'h0);
        expQ.push_back(32'h13);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, addrs[i], 32'h0);
            @(negedge clk);
            got = bus.readData; exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL mis_load%0d: got %h expected %h", i, got, exp); end
            nextCycle();
        end
    endtask

    task automatic test_errstat();
        drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
        expQ.push_back(32'h1);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL errstat_set: got %h expected %h", got, exp); end
        nextCycle();
        drive(1'b1, 1'b1, 32'hFFFF_0008, 32'h1234_5678);
        nextCycle();
        checks++; if (errFlag !== 1'b0) begin errors++; $display("FAIL errstat_clear: got %b expected %b", errFlag, 1'b0); end
        drive(1'b1, 1'b0, 32'hFFFF_000A, 32'h0);
        expQ.push_back(32'h0);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL mis_mmio_read: got %h expected %h", got, exp); end
        nextCycle();
        checks++; if (errFlag !== 1'b1) begin errors++; $display("FAIL errstat_reset: got %b expected %b", errFlag, 1'b1); end
        drive(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
        expQ.push_back(32'hFFFF_000A);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL erraddr_new: got %h expected %h", got, exp); end
        nextCycle();
    endtask

    task automatic test_cycle();
        drive(1'b1, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFE);
        nextCycle();
        drive(1'b1, 1'b0, 32'hFFFF_0004, 32'h0);
        expQ.push_back(32'hFFFF_FFFE);
        expQ.push_back(32'hFFFF_FFFF);
        expQ.push_back(32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = bus.readData; exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL cycle%0d: got %h expected %h", i, got, exp); end
            nextCycle();
        end
    endtask

    task automatic test_gpio();
        drive(1'b1, 1'b1, 32'hFFFF_0000, 32'h0000_A5A5);
        nextCycle();
        checks++; if (gpioOut !== 32'h0000_A5A5) begin errors++; $display("FAIL gpio_out: got %h expected %h", gpioOut, 32'h0000_A5A5); end
        drive(1'b1, 1'b0, 32'hFFFF_0010, 32'h0);
        expQ.push_back(32'h0000_A5A5);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL gpio_alias: got %h expected %h", got, exp); end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [8];
        for (int i = 0; i < 8; i++) begin
            model[i] = $urandom;
            drive(1'b1, 1'b1, 32'h80 + 32'(i * 4), model[i]);
            nextCycle();
        end
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'h0);
            expQ.push_back(model[i]);
            @(negedge clk);
            got = bus.readData; exp = expQ.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, got, exp); end
            nextCycle();
        end
    endtask

    task automatic test_reset_pending();
        drive(1'b1, 1'b1, 32'h40, 32'h0000_5555);
        nextCycle();
        // Make error state nonzero so the reset clear is observable.
        drive(1'b1, 1'b0, 32'h41, 32'h0);
        nextCycle();
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 32'h0000_1234);
        nextCycle();
        checks++; if (gpioOut !== 32'h0) begin errors++; $display("FAIL rstp_gpio: got %h expected %h", gpioOut, 32'h0); end
        checks++; if (errFlag !== 1'b0) begin errors++; $display("FAIL rstp_err: got %b expected %b", errFlag, 1'b0); end
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        expQ.push_back(32'h0);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL rstp_forced0: got %h expected %h", got, exp); end
        nextCycle();
        rst = 1'b1;
        expQ.push_back(32'h0000_5555);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL rstp_ram_kept: got %h expected %h", got, exp); end
        nextCycle();
        drive(1'b0, 1'b0, 32'h40, 32'h0);
        expQ.push_back(32'h0);
        @(negedge clk);
        got = bus.readData; exp = expQ.pop_front();
        checks++; if (got !== exp) begin errors++; $display("FAIL ce_low_read: got %h expected %h", got, exp); end
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_errstat();
        test_cycle();
        test_gpio();
        test_back_to_back();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
